// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, buffers {pc, instr} pairs from the icache
// and presents them show-ahead to decode. Optional pass-through: define FETCHQ_BYPASS_EN.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int INSTSZ = 32,
    parameter int WORDSZ = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WORDSZ-1:0]          entry,
    output logic [WORDSZ-1:0]          fetch_pc,
    output logic                       fetch_en,
    input  logic                       enq_valid,
    input  logic [INSTSZ-1:0]          enq_instr,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [WORDSZ-1:0]          deq_pc,
    output logic [INSTSZ-1:0]          deq_instr,
    input  logic                       flush,
    input  logic [WORDSZ-1:0]          flush_pc,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WORDSZ-1:0] pc_mem    [DEPTH];
    logic [INSTSZ-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          enq_acc;
    logic          enq_wr;
    logic          deq_pop;
    logic          bypass;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // fetch_en deliberately uses the registered full so the icache never sees a comb ready path
    assign fetch_en = !full && !flush;
    assign enq_acc  = enq_valid && !full && !flush;

`ifdef FETCHQ_BYPASS_EN
    assign bypass = empty && enq_valid && deq_ready && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign enq_wr  = enq_acc && !bypass;
    assign deq_pop = !empty && deq_ready && !flush;

    always_comb begin
        deq_valid = 1'b0;
        deq_pc    = '0;
        deq_instr = '0;
        if (bypass) begin
            deq_valid = 1'b1;
            deq_pc    = fetch_pc;
            deq_instr = enq_instr;
        end else if (!empty) begin
            deq_valid = 1'b1;
            deq_pc    = pc_mem[rd_ptr];
            deq_instr = instr_mem[rd_ptr];
        end
    end

    // Storage is data only; its contents are meaningless until count says otherwise
    always_ff @(posedge clk) begin
        if (enq_wr) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= enq_instr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= entry;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (flush) begin
            fetch_pc <= flush_pc;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq_acc)
                fetch_pc <= fetch_pc + WORDSZ'(4);
            if (enq_wr)
                wr_ptr <= wr_ptr + AW'(1);
            if (deq_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({enq_wr, deq_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, INSTSZ=32, WORDSZ=64).
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] entry;
    logic [63:0] fetch_pc;
    logic        fetch_en;
    logic        enq_valid;
    logic [31:0] enq_instr;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_pc;
    logic [31:0] deq_instr;
    logic        flush;
    logic [63:0] flush_pc;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(.DEPTH(4), .INSTSZ(32), .WORDSZ(64)) dut (
        .clk(clk), .reset(reset), .entry(entry),
        .fetch_pc(fetch_pc), .fetch_en(fetch_en),
        .enq_valid(enq_valid), .enq_instr(enq_instr),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc(deq_pc), .deq_instr(deq_instr),
        .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [31:0] ins, input logic dr,
                         input logic fl, input logic [63:0] fpc);
        enq_valid = ev;
        enq_instr = ins;
        deq_ready = dr;
        flush     = fl;
        flush_pc  = fpc;
        #1;
    endtask

    task automatic do_reset(input logic [63:0] e);
        entry = e;
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset(64'h1000);
        n_checks++; if (fetch_pc !== 64'h1000) begin n_fail++; $display("FAIL reset_fetch_pc got %h exp %h", fetch_pc, 64'h1000); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid got %b exp 0", deq_valid); end
        n_checks++; if (deq_pc !== 64'h0 || deq_instr !== 32'h0) begin n_fail++; $display("FAIL reset_deq_data got %h/%h exp 0/0", deq_pc, deq_instr); end
        n_checks++; if (fetch_en !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_en got %b exp 1", fetch_en); end
    endtask

    task automatic test_enqueue();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + 32'(i), 1'b0, 1'b0, 64'h0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL enq_count got %0d exp 3", count); end
        n_checks++; if (fetch_pc !== 64'h100C) begin n_fail++; $display("FAIL enq_fetch_pc got %h exp %h", fetch_pc, 64'h100C); end
        n_checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'h1000) begin n_fail++; $display("FAIL enq_head_pc got %b/%h exp 1/%h", deq_valid, deq_pc, 64'h1000); end
        n_checks++; if (deq_instr !== 32'hA000_0000) begin n_fail++; $display("FAIL enq_head_instr got %h exp %h", deq_instr, 32'hA000_0000); end
    endtask

    task automatic test_full();
        drive(1'b1, 32'hA000_0003, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d exp 4", count); end
        n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL full_fetch_en got %b exp 0", fetch_en); end
        n_checks++; if (fetch_pc !== 64'h1010) begin n_fail++; $display("FAIL full_fetch_pc got %h exp %h", fetch_pc, 64'h1010); end
        tick();
        n_checks++; if (fetch_pc !== 64'h1010 || count !== 3'd4) begin n_fail++; $display("FAIL full_hold got %h/%0d exp %h/4", fetch_pc, count, 64'h1010); end
        // dequeue while full: the enqueue in the same cycle must still be refused
        drive(1'b1, 32'hBAD0_0001, 1'b1, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_deq_count got %0d exp 3", count); end
        n_checks++; if (fetch_en !== 1'b1) begin n_fail++; $display("FAIL full_deq_fetch_en got %b exp 1", fetch_en); end
        n_checks++; if (fetch_pc !== 64'h1010) begin n_fail++; $display("FAIL full_deq_fetch_pc got %h exp %h", fetch_pc, 64'h1010); end
        n_checks++; if (deq_pc !== 64'h1004 || deq_instr !== 32'hA000_0001) begin n_fail++; $display("FAIL full_deq_head got %h/%h exp %h/%h", deq_pc, deq_instr, 64'h1004, 32'hA000_0001); end
    endtask

    task automatic test_flush();
        do_reset(64'h1000);
        drive(1'b1, 32'hC000_0000, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 32'hC000_0001, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 64'h2000);
        n_checks++; if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL flush_fetch_en got %b exp 0", fetch_en); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL flush_deq_valid got %b exp 0", deq_valid); end
        n_checks++; if (fetch_pc !== 64'h2000) begin n_fail++; $display("FAIL flush_fetch_pc got %h exp %h", fetch_pc, 64'h2000); end
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (deq_pc !== 64'h2000 || deq_instr !== 32'h1111_1111 || count !== 3'd1) begin n_fail++; $display("FAIL flush_after got %h/%h/%0d exp %h/%h/1", deq_pc, deq_instr, count, 64'h2000, 32'h1111_1111); end
        // misaligned redirect target is kept as given
        drive(1'b0, 32'h0, 1'b0, 1'b1, 64'h3003);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (fetch_pc !== 64'h3003) begin n_fail++; $display("FAIL flush_misaligned got %h exp %h", fetch_pc, 64'h3003); end
    endtask

    task automatic test_back_to_back();
        do_reset(64'h3000);
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'hE000_0000 + 32'(i), 1'b0, 1'b0, 64'h0);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'hE000_0002 + 32'(i), 1'b1, 1'b0, 64'h0);
            n_checks++; if (deq_pc !== 64'h3000 + 64'(4 * i) || deq_instr !== 32'hE000_0000 + 32'(i) || count !== 3'd2) begin
                n_fail++; $display("FAIL b2b_step%0d got %h/%h/%0d exp %h/%h/2", i, deq_pc, deq_instr, count, 64'h3000 + 64'(4 * i), 32'hE000_0000 + 32'(i));
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd2 || fetch_pc !== 64'h3030 || deq_pc !== 64'h3028) begin n_fail++; $display("FAIL b2b_end got %0d/%h/%h exp 2/%h/%h", count, fetch_pc, deq_pc, 64'h3030, 64'h3028); end
    endtask

    task automatic test_pc_wrap();
        do_reset(64'hFFFF_FFFF_FFFF_FFFC);
        drive(1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 64'h0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (fetch_pc !== 64'h0) begin n_fail++; $display("FAIL wrap_fetch_pc got %h exp 0", fetch_pc); end
        n_checks++; if (deq_pc !== 64'hFFFF_FFFF_FFFF_FFFC || deq_instr !== 32'h5555_AAAA) begin n_fail++; $display("FAIL wrap_deq got %h/%h exp %h/%h", deq_pc, deq_instr, 64'hFFFF_FFFF_FFFF_FFFC, 32'h5555_AAAA); end
    endtask

    task automatic test_reset_mid();
        do_reset(64'h4000);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7000_0000 + 32'(i), 1'b0, 1'b0, 64'h0);
            tick();
        end
        reset = 1'b1;
        drive(1'b1, 32'h7777_7777, 1'b0, 1'b0, 64'h0);
        tick();
        n_checks++; if (count !== 3'd0 || deq_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_count got %0d/%b exp 0/0", count, deq_valid); end
        n_checks++; if (fetch_pc !== 64'h4000 || deq_pc !== 64'h0 || deq_instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_outs got %h/%h/%h exp %h/0/0", fetch_pc, deq_pc, deq_instr, 64'h4000); end
        reset = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        tick();
        n_checks++; if (count !== 3'd0 || fetch_pc !== 64'h4000) begin n_fail++; $display("FAIL rstmid_dropped got %0d/%h exp 0/%h", count, fetch_pc, 64'h4000); end
    endtask

    task automatic test_bypass();
        do_reset(64'h5000);
        drive(1'b1, 32'h9999_0000, 1'b1, 1'b0, 64'h0);
`ifdef FETCHQ_BYPASS_EN
        n_checks++; if (deq_valid !== 1'b1 || deq_pc !== 64'h5000 || deq_instr !== 32'h9999_0000) begin n_fail++; $display("FAIL bypass_same_cycle got %b/%h/%h exp 1/%h/%h", deq_valid, deq_pc, deq_instr, 64'h5000, 32'h9999_0000); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd0 || fetch_pc !== 64'h5004 || deq_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_after got %0d/%h/%b exp 0/%h/0", count, fetch_pc, deq_valid, 64'h5004); end
`else
        n_checks++; if (deq_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_same_cycle got %b exp 0", deq_valid); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
        n_checks++; if (count !== 3'd1 || fetch_pc !== 64'h5004 || deq_pc !== 64'h5000 || deq_instr !== 32'h9999_0000) begin n_fail++; $display("FAIL nobypass_after got %0d/%h/%h/%h exp 1/%h/%h/%h", count, fetch_pc, deq_pc, deq_instr, 64'h5004, 64'h5000, 32'h9999_0000); end
`endif
    endtask

    initial begin
        reset     = 1'b1;
        entry     = 64'h0;
        enq_valid = 1'b0;
        enq_instr = 32'h0;
        deq_ready = 1'b0;
        flush     = 1'b0;
        flush_pc  = 64'h0;
        test_reset();
        test_enqueue();
        test_full();
        test_flush();
        test_back_to_back();
        test_pc_wrap();
        test_reset_mid();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
